// File: rtl/tdc_measure_sequencer_pkg.sv
// Shared definitions for the TDC measurement sequencer.
//
// Holds the FSM state encoding, the default parameter values and a small
// helper that sizes the ARM timeout timer. Imported by the sequencer top,
// the timeout timer and the testbench.
package tdc_measure_sequencer_pkg;

    localparam int TDC_DEFAULT_WIDTH       = 8;
    localparam int TDC_DEFAULT_ARM_TIMEOUT = 1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ARM     = 3'd2,
        ST_MEASURE = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5
    } tdc_state_t;

    // Width of a counter that must hold values 0 .. limit-1.
    // A limit of 1 still needs a one-bit register.
    function automatic int timer_width(input int limit);
        int w;
        w = 1;
        if (limit > 1) begin
            w = $clog2(limit);
        end
        return w;
    endfunction

endpackage

// File: rtl/tdc_timeout_timer.sv
// ARM-phase timeout timer.
//
// Counts clk cycles while run is high, starting from 0 after restart.
// expired is high during the cycle in which the count has reached LIMIT-1
// while run is still high, i.e. in the LIMIT-th consecutive run cycle.
// The count holds at LIMIT-1 until restarted.
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   run      in  count enable (high while the sequencer is in ARM)
//   restart  in  synchronous return of the count to 0
//   expired  out run cycle LIMIT reached (combinational from count/run)
module tdc_timeout_timer
    import tdc_measure_sequencer_pkg::*;
#(
    parameter int LIMIT = TDC_DEFAULT_ARM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int CW = timer_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (restart) begin
            count_next = '0;
        end else if (run && (count_reg != LAST)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = run && (count_reg == LAST);

endmodule

// File: rtl/tdc_measure_sequencer.sv
// Time-to-digital measurement sequencer.
//
// Drives an external cycle counter through one measurement: clear it,
// wait (bounded) for a first edge, let it count until the second edge,
// capture the count and present it under a valid/ack handshake.
// Overflow (counter reached MAX before the second edge) and timeout
// (no first edge within ARM_TIMEOUT cycles) are reported alongside.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   begin a measurement (only looked at in IDLE)
//   abort         in   cancel a measurement in progress
//   edge_in       in   single-cycle pulse from the edge detector
//   count_in      in   current counter value (registered in the counter)
//   clear         out  synchronous clear to the counter
//   en            out  counter increment enable
//   ready         out  sequencer idle
//   busy          out  measurement in progress (CLEAR..CAPTURE)
//   result        out  captured measurement, stable while result_valid
//   result_valid  out  result available
//   result_ack    in   consumer accepts result (only looked at in HOLD)
//   overflow      out  result saturated at MAX
//   timeout       out  no first edge arrived in time
module tdc_measure_sequencer
    import tdc_measure_sequencer_pkg::*;
#(
    parameter int WIDTH       = TDC_DEFAULT_WIDTH,
    parameter int ARM_TIMEOUT = TDC_DEFAULT_ARM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             edge_in,
    input  logic [WIDTH-1:0] count_in,
    output logic             clear,
    output logic             en,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             overflow,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    tdc_state_t       state_reg;
    tdc_state_t       state_next;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             timeout_reg;
    logic             timeout_next;

    logic             timer_run;
    logic             timer_restart;
    logic             timer_expired;

    // Timer is zeroed in CLEAR so that the first ARM cycle sees count 0.
    assign timer_run     = (state_reg == ST_ARM);
    assign timer_restart = (state_reg == ST_CLEAR);

    tdc_timeout_timer #(
        .LIMIT (ARM_TIMEOUT)
    ) u_timeout_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .restart (timer_restart),
        .expired (timer_expired)
    );

    // Next-state and result/flag update.
    // abort pre-empts every transition outside IDLE, including the
    // capture in CAPTURE, so nothing is written on an aborted run.
    always_comb begin
        state_next    = state_reg;
        result_next   = result_reg;
        overflow_next = overflow_reg;
        timeout_next  = timeout_reg;

        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    result_next   = '0;
                    overflow_next = 1'b0;
                    timeout_next  = 1'b0;
                    state_next    = ST_ARM;
                end

                ST_ARM: begin
                    // An edge in the expiry cycle still starts a measurement.
                    if (edge_in) begin
                        state_next = ST_MEASURE;
                    end else if (timer_expired) begin
                        timeout_next = 1'b1;
                        state_next   = ST_CAPTURE;
                    end
                end

                ST_MEASURE: begin
                    // Edge beats MAX: the count is still a real measurement.
                    if (edge_in) begin
                        state_next = ST_CAPTURE;
                    end else if (count_in == MAX_COUNT) begin
                        overflow_next = 1'b1;
                        state_next    = ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    // en is already low here; count_in includes the
                    // increment from the final MEASURE cycle.
                    if (overflow_reg) begin
                        result_next = MAX_COUNT;
                    end else if (timeout_reg) begin
                        result_next = '0;
                    end else begin
                        result_next = count_in;
                    end
                    state_next = ST_HOLD;
                end

                ST_HOLD: begin
                    if (result_ack) begin
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            result_reg   <= result_next;
            overflow_reg <= overflow_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Moore output decode.
    always_comb begin
        clear        = 1'b0;
        en           = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_CLEAR: begin
                clear = 1'b1;
                busy  = 1'b1;
            end
            ST_ARM: begin
                busy = 1'b1;
            end
            ST_MEASURE: begin
                en   = 1'b1;
                busy = 1'b1;
            end
            ST_CAPTURE: begin
                busy = 1'b1;
            end
            ST_HOLD: begin
                result_valid = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign result   = result_reg;
    assign overflow = overflow_reg;
    assign timeout  = timeout_reg;

endmodule
